// File: rtl/round_referee.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : round_referee
//  Description : Referee for a two-player tug-of-war light game. A single lit
//                position moves left/right on player presses. Pushing the
//                light off an edge scores a round, which triggers one-cycle
//                win/lose requests to the external score counters, then a
//                cool-down. A player reaching seven wins ends the game.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_referee #(
    parameter int HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic [2:0] lscore,
    input  logic [2:0] rscore,
    output logic       lwin,
    output logic       llose,
    output logic       rwin,
    output logic       rlose,
    output logic [8:0] pos,
    output logic       game_over,
    output logic [1:0] winner
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_PLAY  = 2'd0;
    localparam logic [1:0] S_SCORE = 2'd1;
    localparam logic [1:0] S_COOL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] c_POS_CENTER = 9'b000010000;
    localparam logic [8:0] c_POS_LEFT   = 9'b100000000;
    localparam logic [8:0] c_POS_RIGHT  = 9'b000000001;
    localparam logic [8:0] c_POS_OFF    = 9'b000000000;

    localparam logic [1:0] c_WIN_NONE   = 2'b00;
    localparam logic [1:0] c_WIN_LEFT   = 2'b10;
    localparam logic [1:0] c_WIN_RIGHT  = 2'b01;

    localparam logic [2:0] c_SCORE_MAX  = 3'd7;

    // Last value of the cool-down counter before returning to play.
    localparam logic [7:0] c_HOLD_LAST  = 8'(HOLD - 1);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [8:0] r_pos;
    logic [7:0] r_cnt;
    logic       r_rnd_left;   // winner of the most recent round: 1 = left
    logic       r_lwin;
    logic       r_llose;
    logic       r_rwin;
    logic       r_rlose;
    logic       r_game_over;
    logic [1:0] r_winner;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic [8:0] w_pos_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_rnd_left_nxt;
    logic       w_lwin_nxt;
    logic       w_llose_nxt;
    logic       w_rwin_nxt;
    logic       w_rlose_nxt;
    logic       w_game_over_nxt;
    logic [1:0] w_winner_nxt;

    // Decoded press / score conditions.
    logic       w_l_only;
    logic       w_r_only;
    logic       w_lmax;
    logic       w_rmax;
    logic       w_final_left;

    assign w_l_only     = L & ~R;
    assign w_r_only     = R & ~L;
    assign w_lmax       = (lscore == c_SCORE_MAX);
    assign w_rmax       = (rscore == c_SCORE_MAX);
    // A tie at seven goes to whoever won the round that caused it.
    assign w_final_left = (w_lmax & w_rmax) ? r_rnd_left : w_lmax;

    // Next-state and next-output decode for the referee FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_cnt_nxt       = r_cnt;
        w_rnd_left_nxt  = r_rnd_left;
        w_lwin_nxt      = 1'b0;
        w_llose_nxt     = 1'b0;
        w_rwin_nxt      = 1'b0;
        w_rlose_nxt     = 1'b0;
        w_game_over_nxt = r_game_over;
        w_winner_nxt    = r_winner;

        case (r_state)
            S_PLAY: begin
                if (w_l_only) begin
                    if (r_pos[8]) begin
                        // Light pushed off the left edge: left takes the round.
                        w_state_nxt    = S_SCORE;
                        w_rnd_left_nxt = 1'b1;
                        w_lwin_nxt     = 1'b1;
                        w_rlose_nxt    = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos << 1;
                    end
                end else if (w_r_only) begin
                    if (r_pos[0]) begin
                        // Light pushed off the right edge: right takes the round.
                        w_state_nxt    = S_SCORE;
                        w_rnd_left_nxt = 1'b0;
                        w_rwin_nxt     = 1'b1;
                        w_llose_nxt    = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos >> 1;
                    end
                end
            end

            S_SCORE: begin
                // Pulses were raised on entry and drop here; lights go dark.
                w_state_nxt = S_COOL;
                w_pos_nxt   = c_POS_OFF;
                w_cnt_nxt   = 8'd0;
            end

            S_COOL: begin
                if ((r_cnt == 8'd0) && (w_lmax || w_rmax)) begin
                    // Scores seen on the first cool-down cycle already include
                    // the update requested during SCORE.
                    w_state_nxt     = S_DONE;
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = w_final_left ? c_WIN_LEFT : c_WIN_RIGHT;
                    w_pos_nxt       = w_final_left ? c_POS_LEFT : c_POS_RIGHT;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = S_PLAY;
                    w_pos_nxt   = c_POS_CENTER;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            S_DONE: begin
                // Terminal until reset; all inputs are ignored.
                w_state_nxt = S_DONE;
            end

            default: begin
                w_state_nxt     = S_PLAY;
                w_pos_nxt       = c_POS_CENTER;
                w_cnt_nxt       = 8'd0;
                w_game_over_nxt = 1'b0;
                w_winner_nxt    = c_WIN_NONE;
            end
        endcase
    end

    // Register all state and outputs; reset is asynchronous and active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_PLAY;
            r_pos       <= c_POS_CENTER;
            r_cnt       <= 8'd0;
            r_rnd_left  <= 1'b0;
            r_lwin      <= 1'b0;
            r_llose     <= 1'b0;
            r_rwin      <= 1'b0;
            r_rlose     <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= c_WIN_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rnd_left  <= w_rnd_left_nxt;
            r_lwin      <= w_lwin_nxt;
            r_llose     <= w_llose_nxt;
            r_rwin      <= w_rwin_nxt;
            r_rlose     <= w_rlose_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------------
    assign lwin      = r_lwin;
    assign llose     = r_llose;
    assign rwin      = r_rwin;
    assign rlose     = r_rlose;
    assign pos       = r_pos;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_round_referee.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_round_referee
//  Description : Scoreboard bench for round_referee. Two instances (HOLD=8 and
//                HOLD=1) share stimulus; a game-level reference model predicts
//                each cycle's outputs, which a monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_referee;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       L     = 1'b0;
    logic       R     = 1'b0;
    logic [2:0] ls    = 3'd0;
    logic [2:0] rs    = 3'd0;

    logic       lwin0, llose0, rwin0, rlose0, go0;
    logic [8:0] pos0;
    logic [1:0] win0;
    logic       lwin1, llose1, rwin1, rlose1, go1;
    logic [8:0] pos1;
    logic [1:0] win1;

    round_referee #(.HOLD(8)) u_dut0 (
        .clk(clk), .reset(rst_n), .L(L), .R(R), .lscore(ls), .rscore(rs),
        .lwin(lwin0), .llose(llose0), .rwin(rwin0), .rlose(rlose0),
        .pos(pos0), .game_over(go0), .winner(win0)
    );

    round_referee #(.HOLD(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .L(L), .R(R), .lscore(ls), .rscore(rs),
        .lwin(lwin1), .llose(llose1), .rwin(rwin1), .rlose(rlose1),
        .pos(pos1), .game_over(go1), .winner(win1)
    );

    always #5 clk = ~clk;

    logic [15:0] w_out0;
    logic [15:0] w_out1;
    assign w_out0 = {pos0, lwin0, llose0, rwin0, rlose0, go0, win0};
    assign w_out1 = {pos1, lwin1, llose1, rwin1, rlose1, go1, win1};

    // Game-level model: phase 0 play, 1 scoring, 2 cooling, 3 over.
    // Light position is a signed offset from centre, +4 = leftmost.
    // Round / game winners: 1 = left, 2 = right.
    typedef struct {
        int ph;
        int p;
        int c;
        int rw;
        int gw;
    } mdl_t;

    int errors = 0;
    int checks = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    mdl_t m0, m1;
    int lcnt = 0;
    int rcnt = 0;

    function automatic mdl_t mrst();
        mdl_t m;
        m.ph = 0; m.p = 0; m.c = 0; m.rw = 0; m.gw = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, bit l, bit r, int lsc, int rsc, int hold);
        mdl_t n = m;
        case (m.ph)
            0: begin
                if (l && !r) begin
                    if (m.p == 4) begin n.ph = 1; n.rw = 1; end
                    else n.p = m.p + 1;
                end else if (r && !l) begin
                    if (m.p == -4) begin n.ph = 1; n.rw = 2; end
                    else n.p = m.p - 1;
                end
            end
            1: begin n.ph = 2; n.c = 0; end
            2: begin
                if (m.c == 0 && (lsc == 7 || rsc == 7)) begin
                    n.ph = 3;
                    if (lsc == 7 && rsc == 7) n.gw = m.rw;
                    else n.gw = (lsc == 7) ? 1 : 2;
                end else if (m.c + 1 >= hold) begin
                    n.ph = 0; n.p = 0;
                end else begin
                    n.c = m.c + 1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    // Packed as {pos, lwin, llose, rwin, rlose, game_over, winner}.
    function automatic logic [15:0] outs(mdl_t m);
        logic [8:0] p;
        logic [3:0] pl;
        logic       go;
        logic [1:0] w;
        p = 9'd0; pl = 4'b0000; go = 1'b0; w = 2'b00;
        if (m.ph == 0 || m.ph == 1) begin
            p = 9'd1 << (m.p + 4);
        end else if (m.ph == 3) begin
            go = 1'b1;
            p  = (m.gw == 1) ? 9'b100000000 : 9'b000000001;
            w  = (m.gw == 1) ? 2'b10 : 2'b01;
        end
        if (m.ph == 1) pl = (m.rw == 1) ? 4'b1001 : 4'b0110;
        return {p, pl, go, w};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got pos=%b lw/ll/rw/rl=%b go=%b win=%b, expected pos=%b lw/ll/rw/rl=%b go=%b win=%b",
                     nm, $time, got[15:7], got[6:3], got[2], got[1:0],
                     exp[15:7], exp[6:3], exp[2], exp[1:0]);
        end
    endtask

    // One clock of stimulus; score counters follow the HOLD=8 game's requests.
    task automatic cyc(input bit l, input bit r);
        @(negedge clk);
        if (m0.ph == 1) begin
            if (m0.rw == 1) begin
                lcnt = (lcnt < 7) ? lcnt + 1 : 7;
                rcnt = (rcnt > 0) ? rcnt - 1 : 0;
            end else begin
                rcnt = (rcnt < 7) ? rcnt + 1 : 7;
                lcnt = (lcnt > 0) ? lcnt - 1 : 0;
            end
        end
        rst_n = 1'b1;
        L  = l;
        R  = r;
        ls = 3'(lcnt);
        rs = 3'(rcnt);
        m0 = step(m0, l, r, lcnt, rcnt, 8);
        m1 = step(m1, l, r, lcnt, rcnt, 1);
        q0.push_back(outs(m0));
        q1.push_back(outs(m1));
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        L = 1'b0;
        R = 1'b0;
        #1;
        m0 = mrst();
        m1 = mrst();
        chk("async_reset_h8", w_out0, outs(m0));
        chk("async_reset_h1", w_out1, outs(m1));
        lcnt = 0; rcnt = 0; ls = 3'd0; rs = 3'd0;
        q0.push_back(outs(m0));
        q1.push_back(outs(m1));
        @(negedge clk);
        q0.push_back(outs(m0));
        q1.push_back(outs(m1));
    endtask

    // Monitor: every cycle the outputs are presented, pop and compare.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("out_h8", w_out0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("out_h1", w_out1, e);
            end
        end
    end

    // Stimulus: directed scenarios, then randomized play.
    initial begin
        int sel;
        m0 = mrst();
        m1 = mrst();
        do_reset();

        // Left walks to the edge, then scores; cool-down back to centre.
        repeat (5) cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b0);

        // Simultaneous presses cancel.
        repeat (10) cyc(1'b1, 1'b1);

        // Right four, left four: back to centre.
        repeat (4) cyc(1'b0, 1'b1);
        repeat (4) cyc(1'b1, 1'b0);

        // Reset in the middle of SCORE cancels the pulse.
        repeat (5) cyc(1'b1, 1'b0);
        do_reset();
        repeat (3) cyc(1'b0, 1'b0);

        // Reset on the third cool-down cycle.
        repeat (5) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        do_reset();
        repeat (4) cyc(1'b0, 1'b0);

        // Right already at seven: right-won round ends the game.
        do_reset();
        rcnt = 7;
        repeat (5) cyc(1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Randomized games with preloaded scores so games actually finish.
        do_reset();
        lcnt = int'($urandom_range(3, 6));
        rcnt = int'($urandom_range(3, 6));
        for (int i = 0; i < 2500; i++) begin
            if ((m0.ph == 3 && $urandom_range(0, 7) == 0) ||
                (m0.ph == 2 && $urandom_range(0, 39) == 0)) begin
                do_reset();
                lcnt = int'($urandom_range(3, 6));
                rcnt = int'($urandom_range(3, 6));
            end else begin
                sel = int'($urandom_range(0, 7));
                case (sel)
                    0, 1, 2: cyc(1'b1, 1'b0);
                    3, 4:    cyc(1'b0, 1'b1);
                    5:       cyc(1'b1, 1'b1);
                    default: cyc(1'b0, 1'b0);
                endcase
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
